uart_tx_feeder: RTL and testbench

- Byte-buffering sequencer placed directly upstream of the UART transceiver's transmit side.
- Accepts bytes from a producer over a valid/ready handshake and stores them in a synchronous FIFO.
- Presents one byte at a time on the transmitter's start/txin inputs and waits for txdone before issuing the next byte.
- Enforces an inter-byte gap so the transmitter has returned to idle before the next start is sampled.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_tx_feeder.sv | 138 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side feeder: FSM encoding and
// the clock/baud relationship that sets the default inter-byte gap.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } feeder_state_t;

  localparam int CLKS_PER_BIT       = 10;
  // Stop bit plus a couple of clocks for the transmitter to settle in idle.
  localparam int GAP_CYCLES_DEF     = CLKS_PER_BIT + 2;
  localparam int TIMEOUT_CYCLES_DEF = 160;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with (AW+1)-bit pointers; the extra MSB tells full
// from empty. Flush drops everything not yet popped by snapping rd to wr.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wdata,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);
  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; wrap-around comes from natural overflow of AW+1 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to the UART
// transmitter, waiting for tx_done plus a settle gap between bytes and
// abandoning a byte if the transmitter never answers.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int AW             = $clog2(DEPTH),
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          err_timeout
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  feeder_state_t state;
  feeder_state_t state_nxt;

  logic [GW-1:0] gap_cnt;
  logic [WW-1:0] wdog;
  logic          wd_expire;
  logic          pop;
  logic          start_set;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wdata (in_data),
    .push  (in_valid),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign in_ready  = !fifo_full;
  assign wd_expire = (wdog == WW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a flush in IDLE pre-empts that cycle's pop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!fifo_empty && !flush) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_done || wd_expire) state_nxt = GAP;
      GAP:       if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    pop       = (state == IDLE) && !fifo_empty && !flush;
    start_set = (state == START);
    busy      = (state != IDLE);
  end

  // Start pulse is registered so the transmitter sees a clean one-clock
  // strobe; it lands one clock after START, together with WAIT_DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
    end else begin
      tx_start <= start_set;
    end
  end

  // Byte handed to the transmitter; stays put until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= 8'h00;
    end else if (pop) begin
      tx_data <= fifo_rdata;
    end
  end

  // Watchdog, gap counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      gap_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        START: begin
          wdog <= '0;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            gap_cnt <= GW'(GAP_CYCLES);
          end else if (wd_expire) begin
            err_timeout <= 1'b1;
            gap_cnt     <= GW'(GAP_CYCLES);
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: bytes are queued as they are
// accepted and popped/compared when tx_start appears; a responder answers
// each start with tx_done after a programmable delay.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic [4:0] level;
  logic       busy;
  logic       err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int done_delay = -1;
  int done_cnt   = 0;
  int start_cnt  = 0;

  uart_tx_feeder #(
    .DEPTH          (16),
    .AW             (4),
    .GAP_CYCLES     (12),
    .TIMEOUT_CYCLES (160)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .level       (level),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every start pulse, plus the tx_done responder.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
    if (tx_start === 1'b1) begin
      start_cnt++;
      if (exp_q.size() == 0) check("unexpected_start", 1, 0);
      else check("tx_data_order", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      if (done_delay > 0) done_cnt = done_delay;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    done_cnt = 0;
    done_delay = -1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("push_wait_timeout", 0, 1);
    in_data = b;
    in_valid = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (!(busy == 1'b0 && level == 5'd0 && exp_q.size() == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", (n < limit) ? 1 : 0, 1);
  endtask

  initial begin
    int s0;
    int n;
    logic [7:0] rb;

    // Reset state
    do_reset();
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_timeout, 0);
    check("rst_tx_data", tx_data, 8'h00);

    // Single byte: latency and gap length
    in_data = 8'hA5;
    in_valid = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);                // after edge k
    in_valid = 1'b0;
    check("single_level_k", level, 1);
    check("single_start_k", tx_start, 0);
    @(negedge clk);                // after k+1
    check("single_start_k1", tx_start, 0);
    check("single_busy_k1", busy, 1);
    @(negedge clk);                // after k+2
    check("single_start_k2", tx_start, 1);
    check("single_data_k2", tx_data, 8'hA5);
    check("single_busy_k2", busy, 1);
    @(negedge clk);
    check("single_start_k3", tx_start, 0);
    done_cnt = 97;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!tx_done && n < 300);
    check("single_done_seen", tx_done, 1);
    repeat (12) @(negedge clk);
    check("single_gap_busy", busy, 1);
    @(negedge clk);
    check("single_idle_busy", busy, 0);
    check("single_err", err_timeout, 0);

    // Burst: fill the FIFO while the first byte is outstanding
    do_reset();
    for (int i = 1; i <= 17; i++) push_byte(8'(i));
    check("burst_level_full", level, 16);
    check("burst_in_ready", in_ready, 0);
    check("burst_first_started", start_cnt > 0, 1);
    done_delay = 5;
    done_cnt = 1;
    wait_idle(2000);
    check("burst_err", err_timeout, 0);

    // Wrap-around: random bytes, random gaps, slow transmitter
    do_reset();
    done_delay = 50;
    s0 = start_cnt;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rb = 8'($urandom);
      push_byte(rb);
    end
    wait_idle(6000);
    check("wrap_start_count", start_cnt - s0, 40);

    // Timeout: transmitter never answers
    do_reset();
    push_byte(8'h3C);
    push_byte(8'h5A);
    n = 0;
    while (tx_start !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", tx_start, 1);
    repeat (159) @(negedge clk);
    check("to_err_before", err_timeout, 0);
    @(negedge clk);
    check("to_err_set", err_timeout, 1);
    check("to_gap_busy", busy, 1);
    repeat (12) @(negedge clk);
    check("to_idle_busy", busy, 0);
    check("to_idle_level", level, 1);
    repeat (2) @(negedge clk);
    check("to_next_start", tx_start, 1);
    check("to_next_data", tx_data, 8'h5A);
    wait_idle(400);
    check("to_err_sticky", err_timeout, 1);

    // Flush after the first byte has launched
    do_reset();
    done_delay = 20;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    check("flush_first_started", start_cnt - s0, 1);
    check("flush_level_before", level, 4);
    flush = 1'b1;
    in_data = 8'hEE;
    in_valid = 1'b1;
    exp_q.delete();
    s0 = start_cnt;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_level_after", level, 0);
    repeat (200) @(negedge clk);
    check("flush_no_more_starts", start_cnt - s0, 0);
    check("flush_inflight_done", busy, 0);
    check("flush_err", err_timeout, 0);

    // Reset in the middle of WAIT_DONE
    do_reset();
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) push_byte(8'h80 + 8'(i));
    check("rstmid_started", start_cnt - s0, 1);
    check("rstmid_level_before", level, 3);
    check("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_level", level, 0);
    check("rstmid_tx_start", tx_start, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_in_ready", in_ready, 1);
    s0 = start_cnt;
    done_cnt = 3;
    repeat (30) @(negedge clk);
    check("rstmid_done_ignored", busy, 0);
    check("rstmid_no_start", start_cnt - s0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
